// File: rtl/leiwand_rv32_lsu.sv
// RV32 load/store unit: turns one byte/half/word core access into a word-aligned
// valid/ready memory transaction and returns extended load data with a done pulse.
module leiwand_rv32_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic        we_r, we_s;
    logic [2:0]  funct3_r, funct3_s;
    logic [1:0]  off_r, off_s;
    logic [31:0] tmo_cnt_r, tmo_cnt_s;
    logic        busy_r, done_r, done_s, mis_r, mis_s, tmo_r, tmo_s, valid_r, valid_s;
    logic [31:0] rdata_r, rdata_s, addr_r, addr_s, wdata_r, wdata_s;
    logic [3:0]  wen_r, wen_s;

    function automatic logic access_illegal(input logic we, input logic [2:0] funct3,
                                            input logic [1:0] off);
        logic bad;
        case (funct3)
            3'd0:    bad = 1'b0;
            3'd1:    bad = off[0];
            3'd2:    bad = (off != 2'd0);
            3'd4:    bad = we;
            3'd5:    bad = we | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_wen(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] wen;
        case (size)
            2'd0:    wen = 4'b0001 << off;
            2'd1:    wen = off[1] ? 4'b1100 : 4'b0011;
            2'd2:    wen = 4'b1111;
            default: wen = 4'b0000;
        endcase
        return wen;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] data;
        case (size)
            2'd0:    data = {4{wdata[7:0]}};
            2'd1:    data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] funct3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] data;
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = word[{off[1], 4'b0000} +: 16];
        case (funct3)
            3'd0:    data = {{24{lane_b[7]}}, lane_b};
            3'd1:    data = {{16{lane_h[15]}}, lane_h};
            3'd4:    data = {24'd0, lane_b};
            3'd5:    data = {16'd0, lane_h};
            default: data = word;
        endcase
        return data;
    endfunction

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s   = state_r;
        we_s      = we_r;
        funct3_s  = funct3_r;
        off_s     = off_r;
        tmo_cnt_s = tmo_cnt_r;
        addr_s    = addr_r;
        wen_s     = wen_r;
        wdata_s   = wdata_r;
        valid_s   = 1'b0;
        done_s    = 1'b0;
        mis_s     = 1'b0;
        tmo_s     = 1'b0;
        rdata_s   = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req) begin
                    we_s     = cpu_we;
                    funct3_s = cpu_funct3;
                    off_s    = cpu_addr[1:0];
                    if (access_illegal(cpu_we, cpu_funct3, cpu_addr[1:0])) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                        mis_s   = 1'b1;
                    end else begin
                        state_s   = ST_ACCESS;
                        valid_s   = 1'b1;
                        tmo_cnt_s = 32'd0;
                        addr_s    = {cpu_addr[31:2], 2'b00};
                        wen_s     = cpu_we ? store_wen(cpu_funct3[1:0], cpu_addr[1:0]) : 4'b0000;
                        wdata_s   = cpu_we ? store_data(cpu_funct3[1:0], cpu_wdata) : 32'd0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // A response in the timeout cycle still completes normally.
                if (mem_ready) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    rdata_s = we_r ? 32'd0 : load_extract(funct3_r, off_r, mem_rdata);
                end else if ((TIMEOUT_CYCLES != 32'd0) && (tmo_cnt_r == TIMEOUT_CYCLES)) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    tmo_s   = 1'b1;
                end else begin
                    valid_s = 1'b1;
                    if (tmo_cnt_r != 32'hFFFF_FFFF) begin
                        tmo_cnt_s = tmo_cnt_r + 32'd1;
                    end else begin
                        tmo_cnt_s = tmo_cnt_r;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            we_r      <= 1'b0;
            funct3_r  <= 3'd0;
            off_r     <= 2'd0;
            tmo_cnt_r <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            mis_r     <= 1'b0;
            tmo_r     <= 1'b0;
            valid_r   <= 1'b0;
            rdata_r   <= 32'd0;
            addr_r    <= 32'd0;
            wen_r     <= 4'd0;
            wdata_r   <= 32'd0;
        end else begin
            state_r   <= state_s;
            we_r      <= we_s;
            funct3_r  <= funct3_s;
            off_r     <= off_s;
            tmo_cnt_r <= tmo_cnt_s;
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= done_s;
            mis_r     <= mis_s;
            tmo_r     <= tmo_s;
            valid_r   <= valid_s;
            rdata_r   <= rdata_s;
            addr_r    <= addr_s;
            wen_r     <= wen_s;
            wdata_r   <= wdata_s;
        end
    end

    assign cpu_busy     = busy_r;
    assign cpu_done     = done_r;
    assign cpu_rdata    = rdata_r;
    assign err_misalign = mis_r;
    assign err_timeout  = tmo_r;
    assign mem_valid    = valid_r;
    assign mem_wen      = wen_r;
    assign mem_addr     = addr_r;
    assign mem_wdata    = wdata_r;

endmodule

// File: tb/tb_leiwand_rv32_lsu.sv
// Self-checking bench for leiwand_rv32_lsu: scoreboard of expected completions
// against a small latency-programmable word memory.
module tb_leiwand_rv32_lsu;

    logic        clk, rst;
    logic        cpu_req, cpu_we, cpu_busy, cpu_done, err_misalign, err_timeout;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        mem_valid, mem_ready;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        longint      t;
        logic [31:0] rdata;
        logic        mis;
        logic        tmo;
    } exp_t;

    exp_t        sb[$];
    exp_t        got;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_arr[256];
    int          mem_lat = 0;
    logic        stale_en = 1'b0;

    leiwand_rv32_lsu #(.TIMEOUT_CYCLES(32'd4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .err_misalign(err_misalign), .err_timeout(err_timeout),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory model: registered ready after mem_lat valid cycles, optional stale extra ready.
    initial begin
        logic        nxt_ready, responded, stale_pend;
        logic [31:0] nxt_rdata;
        int          vcnt;
        nxt_ready = 1'b0; nxt_rdata = 32'd0; responded = 1'b0; stale_pend = 1'b0; vcnt = 0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = nxt_ready;
            mem_rdata = nxt_rdata;
            nxt_ready = 1'b0;
            if (stale_pend) begin
                nxt_ready  = 1'b1;
                stale_pend = 1'b0;
            end
            if (!mem_valid) begin
                vcnt = 0;
                responded = 1'b0;
            end else if (!responded) begin
                if (vcnt >= mem_lat) begin
                    nxt_ready  = 1'b1;
                    responded  = 1'b1;
                    stale_pend = stale_en;
                    nxt_rdata  = mem_arr[mem_addr[9:2]];
                    for (int b = 0; b < 4; b++) begin
                        if (mem_wen[b]) mem_arr[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end else begin
                    vcnt++;
                end
            end
        end
    end

    // Completion monitor: every cpu_done must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst && cpu_done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                got = sb.pop_front();
                chk("done_time", 32'($time), 32'(got.t));
                chk("cpu_rdata", cpu_rdata, got.rdata);
                chk("err_misalign", 32'(err_misalign), 32'(got.mis));
                chk("err_timeout", 32'(err_timeout), 32'(got.tmo));
            end
        end
    end

    task automatic lsu_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] xwen,
                          input logic [31:0] xwdata, input logic [31:0] xrdata,
                          input logic xmis, input logic xtmo, input int k, input logic hold);
        exp_t e;
        int   n;
        logic seen_valid;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        e.t = $time + longint'(10 * k - 5);
        e.rdata = xrdata; e.mis = xmis; e.tmo = xtmo;
        sb.push_back(e);
        #1;
        if (!hold) cpu_req = 1'b0;
        @(negedge clk);
        chk("cpu_busy", 32'(cpu_busy), 32'd1);
        seen_valid = mem_valid;
        if (!xmis) begin
            chk("mem_valid", 32'(mem_valid), 32'd1);
            chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
            chk("mem_wen", 32'(mem_wen), 32'(xwen));
            if (we) chk("mem_wdata", mem_wdata, xwdata);
        end
        n = 0;
        while (cpu_busy && n < 40) begin
            @(negedge clk);
            seen_valid = seen_valid | mem_valid;
            n++;
        end
        if (cpu_busy) chk("busy_bound", 32'd1, 32'd0);
        if (xmis) chk("illegal_no_valid", 32'(seen_valid), 32'd0);
        cpu_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'd0;
        mem_arr[8'h40] = 32'h80FF_1234;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_funct3 = 3'd0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(cpu_busy), 32'd0);
        chk("rst_done", 32'(cpu_done), 32'd0);
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_outs", mem_addr | mem_wdata | cpu_rdata | 32'(mem_wen), 32'd0);
        chk("rst_errs", 32'({err_misalign, err_timeout}), 32'd0);
        rst = 1'b0;

        // we f3 addr wdata xwen xwdata xrdata mis tmo k hold
        lsu_op(1'b0, 3'd0, 32'h103, 32'd0, 4'b0000, 32'd0, 32'hFFFF_FF80, 1'b0, 1'b0, 3, 1'b0);
        lsu_op(1'b0, 3'd4, 32'h103, 32'd0, 4'b0000, 32'd0, 32'h0000_0080, 1'b0, 1'b0, 3, 1'b0);
        lsu_op(1'b1, 3'd1, 32'h22, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'd0, 1'b0, 1'b0, 3, 1'b0);
        lsu_op(1'b1, 3'd0, 32'h41, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, 32'd0, 1'b0, 1'b0, 3, 1'b0);
        lsu_op(1'b0, 3'd2, 32'h41, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0, 1, 1'b0);
        lsu_op(1'b1, 3'd4, 32'h40, 32'd5, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0, 1, 1'b0);
        lsu_op(1'b0, 3'd1, 32'h1, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1, 1'b0, 1, 1'b0);

        // Silent memory, then a response landing exactly on the timeout cycle.
        mem_lat = 1000;
        lsu_op(1'b0, 3'd2, 32'h0, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1, 6, 1'b0);
        mem_lat = 3;
        lsu_op(1'b0, 3'd2, 32'h100, 32'd0, 4'b0000, 32'd0, 32'h80FF_1234, 1'b0, 1'b0, 6, 1'b0);

        // Back-to-back store/load with stale ready in DONE and cpu_req held high.
        mem_lat = 0; stale_en = 1'b1;
        lsu_op(1'b1, 3'd2, 32'h80, 32'h1234_5678, 4'b1111, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 3, 1'b0);
        lsu_op(1'b0, 3'd2, 32'h80, 32'd0, 4'b0000, 32'd0, 32'h1234_5678, 1'b0, 1'b0, 3, 1'b1);
        stale_en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of an access drops it without a completion.
        mem_lat = 1000;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'd2; cpu_addr = 32'h0;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(mem_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_valid", 32'(mem_valid), 32'd0);
        chk("post_rst_busy", 32'(cpu_busy), 32'd0);
        repeat (8) @(negedge clk);
        chk("post_rst_idle", 32'(cpu_busy), 32'd0);

        mem_lat = 0;
        mem_arr[0] = 32'h8001_0000;
        lsu_op(1'b0, 3'd1, 32'h2, 32'd0, 4'b0000, 32'd0, 32'hFFFF_8001, 1'b0, 1'b0, 3, 1'b0);
        lsu_op(1'b0, 3'd5, 32'h2, 32'd0, 4'b0000, 32'd0, 32'h0000_8001, 1'b0, 1'b0, 3, 1'b0);
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/leiwand_rv32_lsu.md
# leiwand_rv32_lsu

Load/store unit between the rv32 core's execute stage and the word-wide data memory (simple_mem-style valid/ready port). It accepts one byte/halfword/word load or store per request and checks alignment. It converts the access into a word-aligned memory transaction with byte write-enables, then returns sign- or zero-extended load data with a one-cycle completion pulse. The unit is RV32 only: data and address are 32 bits and write-enables are 4 bits.

## Interface
- TIMEOUT_CYCLES, 255: cycles to wait for mem_ready before aborting; 0 disables the timeout.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- cpu_req  in  1  start request; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_funct3  in  3  RV32 funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_busy  out  1  state != IDLE.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  extended load data; valid while cpu_done=1; 0 for stores and errors.
- err_misalign  out  1  qualifies cpu_done: misaligned access or illegal funct3.
- err_timeout  out  1  qualifies cpu_done: memory did not respond.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory response; registered, and may stay high one cycle after mem_valid falls.
- mem_wen  out  4  byte write-enables; 0 for loads.
- mem_addr  out  32  {cpu_addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word; valid in the cycle mem_ready=1.

## Operation
- States:
  - IDLE: mem_valid=0. On cpu_req, latch the request. An illegal access goes to DONE with err_misalign; otherwise go to ACCESS.
  - ACCESS: mem_valid=1.
    - mem_ready=1: latch the extracted data and go to DONE.
    - Timeout counter reaches TIMEOUT_CYCLES: go to DONE with err_timeout.
  - DONE: one cycle. mem_valid=0, cpu_done=1. mem_ready is ignored because it may be stale. Next state is IDLE.
- Illegal accesses:
  - funct3 values 3, 6, 7 for loads; 3 to 7 for stores.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - An illegal access never asserts mem_valid.
- Store lane mapping:
  - SB: mem_wen = 4'b0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_wen = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_wen = 4'b1111; mem_wdata = wdata.
- Load extraction:
  - Byte lane = mem_rdata >> (8*addr[1:0]).
  - Halfword = mem_rdata >> (16*addr[1]).
  - LB and LH sign-extend bit 7 and bit 15 respectively; LBU and LHU zero-extend; LW passes the word.
- mem_addr, mem_wen and mem_wdata are registered at acceptance and held stable through ACCESS. Memory may repeat an identical write while valid stays high; this is harmless.
- The timeout counter clears on entry to ACCESS, increments each ACCESS cycle, and saturates.
- cpu_req outside IDLE is ignored, not queued.

## Timing
- Reset: all outputs become 0 and the state goes to IDLE on the clock edge where rst=1, including mid-ACCESS; the in-flight transaction is dropped with no cpu_done.
- Request sampled at edge E0 (cycle 0). mem_valid is high from cycle 1.
- With a one-cycle memory: mem_ready=1 in cycle 2, mem_valid falls at the end of cycle 2, and cpu_done=1 in cycle 3. Next request is accepted in cycle 4.
- Load and store latency is therefore 3 cycles. The throughput floor is one access per 4 cycles.
- Illegal access: cpu_done with err_misalign in cycle 1.
- Timeout with TIMEOUT_CYCLES=N: cpu_done with err_timeout N+1 cycles after mem_valid rose.
- mem_ready=1 and the timeout in the same cycle: the response wins (err_timeout=0).
- mem_ready seen in DONE or IDLE: no effect.

## Test plan
- LB at addr 0x103, mem_rdata 0x80FF_1234 → mem_wen 0, mem_addr 0x100, cpu_rdata 0xFFFF_FF80, cpu_done in cycle 3; LBU at the same address → 0x0000_0080.
- SH at addr 0x22, wdata 0xDEAD_BEEF → mem_wen 4'b1100, mem_wdata 0xBEEF_BEEF, mem_addr 0x20, cpu_rdata 0.
- LW at 0x41 → err_misalign=1 and cpu_done in cycle 1, mem_valid never asserted; SW funct3=4 → same error.
- Memory holds mem_ready=0 with TIMEOUT_CYCLES=4 → err_timeout pulse 5 cycles after mem_valid rose, then IDLE; repeat with mem_ready arriving in the same cycle as the timeout → normal completion, err_timeout=0.
- Back-to-back SW then LW to 0x80 with data 0x1234_5678 → the load returns 0x1234_5678; stale mem_ready in DONE is ignored; cpu_req held high during busy is accepted only once per IDLE.
- Assert rst for one cycle during ACCESS → mem_valid=0, cpu_busy=0 next cycle, no cpu_done; a subsequent LH at 0x2, mem_rdata 0x8001_0000 → cpu_rdata 0xFFFF_8001.
